// File: rtl/balu_rs.sv
// Branch reservation station for balu: buffers compare ops, captures operands from the
// writeback bus, issues the oldest ready op and forwards the balu result as a done report.
module balu_rs #(
    parameter int WIDTH   = 32,
    parameter int RSBIT   = 3,
    parameter int ENTRIES = 4,
    parameter int PTAG    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [RSBIT-1:0] disp_rs,
    input  logic [2:0]       disp_op,
    input  logic             disp_lrdy,
    input  logic [WIDTH-1:0] disp_lval,
    input  logic [PTAG-1:0]  disp_ltag,
    input  logic             disp_rrdy,
    input  logic [WIDTH-1:0] disp_rval,
    input  logic [PTAG-1:0]  disp_rtag,
    input  logic             wb_valid,
    input  logic [PTAG-1:0]  wb_tag,
    input  logic [WIDTH-1:0] wb_data,
    output logic [RSBIT-1:0] iss_rs,
    output logic [2:0]       iss_op,
    output logic [WIDTH-1:0] iss_vl,
    output logic [WIDTH-1:0] iss_vr,
    input  logic [RSBIT-1:0] res_rs,
    input  logic             res_taken,
    output logic             done_valid,
    output logic [RSBIT-1:0] done_rs,
    output logic             done_taken
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {FREE, WAIT, READY} state_t;

    state_t           st     [ENTRIES];
    logic [RSBIT-1:0] e_rs   [ENTRIES];
    logic [2:0]       e_op   [ENTRIES];
    logic             e_lrdy [ENTRIES];
    logic [WIDTH-1:0] e_lval [ENTRIES];
    logic [PTAG-1:0]  e_ltag [ENTRIES];
    logic             e_rrdy [ENTRIES];
    logic [WIDTH-1:0] e_rval [ENTRIES];
    logic [PTAG-1:0]  e_rtag [ENTRIES];
    logic [3:0]       e_age  [ENTRIES];

    logic [3:0]         age_cnt;
    logic               flush_d;
    logic               free_found;
    logic               rdy_found;
    logic               disp_fire;
    logic               res_ok;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      rdy_idx;
    logic [3:0]         age_diff;
    logic               d_lrdy;
    logic               d_rrdy;
    logic [WIDTH-1:0]   d_lval;
    logic [WIDTH-1:0]   d_rval;
    logic [ENTRIES-1:0] cap_l;
    logic [ENTRIES-1:0] cap_r;
    logic [ENTRIES-1:0] nxt_free;

    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so the
    // loop can refine a running result without inferring latches; clocked state uses '<='.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        // Oldest-ready scan: a candidate replaces the current pick when the pick's stamp
        // is 1..7 ahead of it modulo 16.
        rdy_found = 1'b0;
        rdy_idx   = '0;
        age_diff  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            age_diff = e_age[rdy_idx] - e_age[i];
            if (st[i] == READY && (!rdy_found || (age_diff != 4'd0 && !age_diff[3]))) begin
                rdy_found = 1'b1;
                rdy_idx   = IW'(i);
            end
        end
    end

    assign disp_fire = disp_valid && disp_ready && free_found && !flush;
    assign d_lrdy    = disp_lrdy || (wb_valid && wb_tag == disp_ltag);
    assign d_rrdy    = disp_rrdy || (wb_valid && wb_tag == disp_rtag);
    assign d_lval    = disp_lrdy ? disp_lval : wb_data;
    assign d_rval    = disp_rrdy ? disp_rval : wb_data;
    assign res_ok    = (res_rs != '0) && !flush && !flush_d;

    always_comb begin
        cap_l    = '0;
        cap_r    = '0;
        nxt_free = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cap_l[i] = (st[i] == WAIT) && !e_lrdy[i] && wb_valid && (wb_tag == e_ltag[i]);
            cap_r[i] = (st[i] == WAIT) && !e_rrdy[i] && wb_valid && (wb_tag == e_rtag[i]);
            nxt_free[i] = flush
                || (st[i] == FREE && !(disp_fire && free_idx == IW'(i)))
                || (st[i] == READY && rdy_found && rdy_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) st[i] <= FREE;
            age_cnt    <= '0;
            flush_d    <= 1'b0;
            disp_ready <= 1'b1;
            iss_rs     <= '0;
            iss_op     <= '0;
            iss_vl     <= '0;
            iss_vr     <= '0;
            done_valid <= 1'b0;
            done_rs    <= '0;
            done_taken <= 1'b0;
        end else begin
            flush_d    <= flush;
            disp_ready <= |nxt_free;
            done_valid <= res_ok;
            done_rs    <= res_ok ? res_rs : '0;
            done_taken <= res_ok && res_taken;
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) st[i] <= FREE;
                iss_rs <= '0;
                iss_op <= '0;
                iss_vl <= '0;
                iss_vr <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    case (st[i])
                        FREE: begin
                            if (disp_fire && free_idx == IW'(i))
                                st[i] <= (d_lrdy && d_rrdy) ? READY : WAIT;
                        end
                        WAIT: begin
                            if ((e_lrdy[i] || cap_l[i]) && (e_rrdy[i] || cap_r[i]))
                                st[i] <= READY;
                        end
                        READY: begin
                            if (rdy_found && rdy_idx == IW'(i))
                                st[i] <= FREE;
                        end
                        default: st[i] <= FREE;
                    endcase
                end
                if (disp_fire) age_cnt <= age_cnt + 4'd1;
                if (rdy_found) begin
                    iss_rs <= e_rs[rdy_idx];
                    iss_op <= e_op[rdy_idx];
                    iss_vl <= e_lval[rdy_idx];
                    iss_vr <= e_rval[rdy_idx];
                end else begin
                    iss_rs <= '0;
                    iss_op <= '0;
                    iss_vl <= '0;
                    iss_vr <= '0;
                end
            end
        end
    end

    // NOTE: entry payload has no reset; it is only read while the entry's state says it is
    // live, and the state array above is what reset clears.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (disp_fire && free_idx == IW'(i)) begin
                e_rs[i]   <= disp_rs;
                e_op[i]   <= disp_op;
                e_lrdy[i] <= d_lrdy;
                e_lval[i] <= d_lval;
                e_ltag[i] <= disp_ltag;
                e_rrdy[i] <= d_rrdy;
                e_rval[i] <= d_rval;
                e_rtag[i] <= disp_rtag;
                e_age[i]  <= age_cnt;
            end else begin
                if (cap_l[i]) begin
                    e_lrdy[i] <= 1'b1;
                    e_lval[i] <= wb_data;
                end
                if (cap_r[i]) begin
                    e_rrdy[i] <= 1'b1;
                    e_rval[i] <= wb_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_balu_rs.sv
// Scoreboard bench for balu_rs: a queue-based reference predicts issue and done traffic,
// and a negedge monitor compares whatever the DUT presents.
module tb_balu_rs;
    localparam int WIDTH   = 32;
    localparam int RSBIT   = 3;
    localparam int ENTRIES = 4;
    localparam int PTAG    = 5;
    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_LT = 3'd2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             disp_valid = 1'b0;
    logic             disp_ready;
    logic [RSBIT-1:0] disp_rs = '0;
    logic [2:0]       disp_op = '0;
    logic             disp_lrdy = 1'b0;
    logic [WIDTH-1:0] disp_lval = '0;
    logic [PTAG-1:0]  disp_ltag = '0;
    logic             disp_rrdy = 1'b0;
    logic [WIDTH-1:0] disp_rval = '0;
    logic [PTAG-1:0]  disp_rtag = '0;
    logic             wb_valid = 1'b0;
    logic [PTAG-1:0]  wb_tag = '0;
    logic [WIDTH-1:0] wb_data = '0;
    logic [RSBIT-1:0] iss_rs;
    logic [2:0]       iss_op;
    logic [WIDTH-1:0] iss_vl;
    logic [WIDTH-1:0] iss_vr;
    logic [RSBIT-1:0] res_rs = '0;
    logic             res_taken = 1'b0;
    logic             done_valid;
    logic [RSBIT-1:0] done_rs;
    logic             done_taken;

    balu_rs #(.WIDTH(WIDTH), .RSBIT(RSBIT), .ENTRIES(ENTRIES), .PTAG(PTAG)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rs(disp_rs), .disp_op(disp_op),
        .disp_lrdy(disp_lrdy), .disp_lval(disp_lval), .disp_ltag(disp_ltag),
        .disp_rrdy(disp_rrdy), .disp_rval(disp_rval), .disp_rtag(disp_rtag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .iss_rs(iss_rs), .iss_op(iss_op), .iss_vl(iss_vl), .iss_vr(iss_vr),
        .res_rs(res_rs), .res_taken(res_taken),
        .done_valid(done_valid), .done_rs(done_rs), .done_taken(done_taken)
    );

    always #5 clk = ~clk;

    function automatic logic resolve(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        case (op)
            OP_EQ:   return a == b;
            OP_NE:   return a != b;
            OP_LT:   return a < b;
            default: return 1'b0;
        endcase
    endfunction

    // One-cycle balu stand-in fed by the DUT's issue port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_rs    <= '0;
            res_taken <= 1'b0;
        end else begin
            res_rs    <= iss_rs;
            res_taken <= resolve(iss_op, iss_vl, iss_vr);
        end
    end

    typedef struct {
        int               seq;
        logic [RSBIT-1:0] rs;
        logic [2:0]       op;
        bit               lr;
        bit               rr;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] rv;
        logic [PTAG-1:0]  lt;
        logic [PTAG-1:0]  rt;
    } op_t;
    typedef struct {
        int               cyc;
        logic [RSBIT-1:0] rs;
        logic [2:0]       op;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] rv;
    } iss_t;
    typedef struct {
        int               cyc;
        logic [RSBIT-1:0] rs;
        logic             taken;
    } done_t;

    op_t   pend[$];
    iss_t  exp_iss[$];
    done_t exp_done[$];
    int    cyc = 0;
    int    seq = 0;
    int    n_pass = 0;
    int    n_total = 0;
    bit               p1_v = 0, p2_v = 0;
    logic [RSBIT-1:0] p1_rs = '0, p2_rs = '0;
    logic             p1_tk = 0, p2_tk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: pending ops ordered by unbounded dispatch sequence, plus the balu/done pipe.
    always @(posedge clk) begin : model
        int   n_start;
        int   pick;
        op_t  o;
        if (rst_n) begin
            cyc++;
            n_start = pend.size();
            if (p2_v && !flush) exp_done.push_back('{cyc, p2_rs, p2_tk});
            p2_v  = p1_v && !flush;
            p2_rs = p1_rs;
            p2_tk = p1_tk;
            p1_v  = 0;
            if (flush) begin
                pend.delete();
            end else begin
                pick = -1;
                foreach (pend[i])
                    if (pend[i].lr && pend[i].rr && (pick < 0 || pend[i].seq < pend[pick].seq))
                        pick = i;
                if (pick >= 0) begin
                    o = pend[pick];
                    exp_iss.push_back('{cyc, o.rs, o.op, o.lv, o.rv});
                    p1_v  = 1;
                    p1_rs = o.rs;
                    p1_tk = resolve(o.op, o.lv, o.rv);
                    pend.delete(pick);
                end
                foreach (pend[i]) begin
                    o = pend[i];
                    if (!o.lr && wb_valid && wb_tag == o.lt) begin o.lr = 1; o.lv = wb_data; end
                    if (!o.rr && wb_valid && wb_tag == o.rt) begin o.rr = 1; o.rv = wb_data; end
                    pend[i] = o;
                end
                if (disp_valid && n_start < ENTRIES) begin
                    o.seq = seq;
                    o.rs  = disp_rs;
                    o.op  = disp_op;
                    o.lt  = disp_ltag;
                    o.rt  = disp_rtag;
                    o.lr  = disp_lrdy || (wb_valid && wb_tag == disp_ltag);
                    o.rr  = disp_rrdy || (wb_valid && wb_tag == disp_rtag);
                    o.lv  = disp_lrdy ? disp_lval : wb_data;
                    o.rv  = disp_rrdy ? disp_rval : wb_data;
                    pend.push_back(o);
                    seq++;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        iss_t  ei;
        done_t ed;
        if (rst_n && cyc > 0) begin
            check("disp_ready", disp_ready, pend.size() < ENTRIES);
            if (iss_rs != '0 || (exp_iss.size() > 0 && exp_iss[0].cyc <= cyc)) begin
                if (exp_iss.size() == 0) begin
                    check("iss_unexpected", iss_rs, 0);
                end else begin
                    ei = exp_iss.pop_front();
                    check("iss_cycle", cyc, ei.cyc);
                    check("iss_rs", iss_rs, ei.rs);
                    check("iss_op", iss_op, ei.op);
                    check("iss_vl", iss_vl, ei.lv);
                    check("iss_vr", iss_vr, ei.rv);
                end
            end
            if (done_valid || (exp_done.size() > 0 && exp_done[0].cyc <= cyc)) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", done_valid, 0);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_cycle", cyc, ed.cyc);
                    check("done_valid", done_valid, 1);
                    check("done_rs", done_rs, ed.rs);
                    check("done_taken", done_taken, ed.taken);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        disp_valid = 0;
        wb_valid   = 0;
        flush      = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic disp(input logic [RSBIT-1:0] rs, input logic [2:0] op,
                        input logic lr, input logic [WIDTH-1:0] lv, input logic [PTAG-1:0] lt,
                        input logic rr, input logic [WIDTH-1:0] rv, input logic [PTAG-1:0] rt);
        disp_valid = 1;
        disp_rs    = rs;
        disp_op    = op;
        disp_lrdy  = lr;
        disp_lval  = lv;
        disp_ltag  = lt;
        disp_rrdy  = rr;
        disp_rval  = rv;
        disp_rtag  = rt;
    endtask

    task automatic wb(input logic [PTAG-1:0] tag, input logic [WIDTH-1:0] data);
        wb_valid = 1;
        wb_tag   = tag;
        wb_data  = data;
    endtask

    initial begin
        #12;
        check("rst_iss_rs", iss_rs, 0);
        check("rst_iss_op", iss_op, 0);
        check("rst_iss_vl", iss_vl, 0);
        check("rst_iss_vr", iss_vr, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_rs", done_rs, 0);
        check("rst_done_taken", done_taken, 0);
        check("rst_disp_ready", disp_ready, 1);
        @(negedge clk);
        rst_n = 1;
        idle(10);

        // Single ready op: issue next edge, done three edges after dispatch.
        disp(1, OP_EQ, 1, 5, 0, 1, 5, 0); step();
        idle(4);

        // Younger ready op overtakes an older one still waiting on tag 7.
        disp(2, OP_EQ, 0, 0, 7, 1, 9, 0); step();
        disp(3, OP_LT, 1, 1, 0, 1, 2, 0); step();
        idle(2);
        wb(7, 9); step();
        idle(5);

        // Fill all entries waiting on tag 3, try one more, then wake all at once.
        for (int i = 1; i <= 4; i++) begin
            disp(RSBIT'(i), OP_NE, 0, 0, 3, 1, WIDTH'(i), 0); step();
        end
        disp(5, OP_EQ, 1, 0, 0, 1, 0, 0); step();
        wb(3, 2); step();
        idle(8);

        // Writeback bypass on the dispatch cycle.
        disp(5, OP_EQ, 0, 0, 12, 1, 42, 0); wb(12, 42); step();
        idle(4);

        // Back-to-back ops across the age-counter wrap.
        for (int i = 0; i < 20; i++) begin
            disp(RSBIT'(i % 7 + 1), 3'(i % 3), 1, WIDTH'(i), 0, 1, WIDTH'(19 - i), 0); step();
        end
        idle(4);

        // Flush with three waiting entries and one op in balu; flush-cycle dispatch dropped.
        for (int i = 1; i <= 3; i++) begin
            disp(RSBIT'(i), OP_EQ, 0, 0, 20, 1, 0, 0); step();
        end
        disp(4, OP_LT, 1, 3, 0, 1, 8, 0); step();
        step();
        flush = 1;
        disp(5, OP_EQ, 1, 1, 0, 1, 1, 0); step();
        idle(5);
        wb(20, 0); step();
        idle(4);

        // Random traffic; writebacks alternate tags 1/2 every cycle so waits stay short.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 60)
                disp(RSBIT'($urandom_range(1, 7)), 3'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 3)), PTAG'($urandom_range(1, 2)),
                     1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 3)), PTAG'($urandom_range(1, 2)));
            wb(PTAG'(c % 2 + 1), WIDTH'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) < 3) flush = 1;
            step();
        end
        idle(10);

        check("iss_queue_drained", exp_iss.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
